// File: rtl/apb_pkg.sv
// Shared APB response-mux definitions: phase encoding, default slave count
// and the watchdog counter width helper.
package apb_pkg;

    localparam int NUM_APB_SLAVES = 12;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_FORCE  = 2'd3
    } apb_state_e;

    // Bits needed to hold 0..timeout, never less than one.
    function automatic int cnt_width(input int timeout);
        int w;
        w = 1;
        for (int i = 1; i < 32; i++)
            if ((1 << i) < timeout + 1) w = i + 1;
        return w;
    endfunction

endpackage

// File: rtl/apb_onehot_sel.sv
// Lowest-index-wins select of one W-bit slot out of N packed slots.
// Zero select yields zero.
module apb_onehot_sel #(
    parameter int N = 12,
    parameter int W = 32
) (
    input  logic [N-1:0]   sel,
    input  logic [N*W-1:0] data,
    output logic [W-1:0]   out
);

    // Scan from the top down so the lowest set bit is the last, winning write.
    always_comb begin
        out = '0;
        for (int i = N - 1; i >= 0; i--)
            if (sel[i]) out = data[i*W +: W];
    end

endmodule

// File: rtl/apb_rsp_mux.sv
// APB response multiplexer with access-phase watchdog. Routes the selected
// slave's PRDATA/PREADY/PSLVERR back to the bridge, forces an error
// completion on a stalled or unselected access, and keeps debug flags.
module apb_rsp_mux
    import apb_pkg::*;
#(
    parameter int NUM_SLAVES = NUM_APB_SLAVES,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                             PCLK,
    input  logic                             PRESET,
    input  logic [NUM_SLAVES-1:0]            psel,
    input  logic                             penable,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata_s,
    input  logic [NUM_SLAVES-1:0]            pready_s,
    input  logic [NUM_SLAVES-1:0]            pslverr_s,
    input  logic                             err_clr,
    output logic [DATA_WIDTH-1:0]            prdata,
    output logic                             pready,
    output logic                             pslverr,
    output logic                             err_multi,
    output logic                             err_timeout,
    output logic                             err_nosel,
    output logic                             last_err
);

    localparam int               CNT_W   = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    apb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_cur;

    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_rdy, sel_err;
    logic                  any_sel, multi, in_force, in_access, nosel, hit_limit;

    apb_onehot_sel #(.N(NUM_SLAVES), .W(DATA_WIDTH)) u_sel_data (
        .sel (psel), .data (prdata_s), .out (sel_data)
    );
    apb_onehot_sel #(.N(NUM_SLAVES), .W(1)) u_sel_rdy (
        .sel (psel), .data (pready_s), .out (sel_rdy)
    );
    apb_onehot_sel #(.N(NUM_SLAVES), .W(1)) u_sel_err (
        .sel (psel), .data (pslverr_s), .out (sel_err)
    );

    assign any_sel   = |psel;
    assign multi     = |(psel & (psel - NUM_SLAVES'(1)));
    assign in_force  = (state_q == ST_FORCE);
    assign in_access = !in_force && penable && any_sel;
    assign nosel     = !in_force && penable && !any_sel;

    // The first access cycle arrives with the state still in SETUP/IDLE, so
    // the stall count is only carried over while we were already in ACCESS.
    assign cnt_cur   = (state_q == ST_ACCESS) ? cnt_q : '0;
    assign hit_limit = (TIMEOUT != 0) && (cnt_cur == CNT_LIM);

    // Response path: forced/no-select error completions override the slave.
    always_comb begin
        prdata  = '0;
        pready  = 1'b0;
        pslverr = 1'b0;
        if (PRESET) begin
            prdata = '0;
        end else if (in_force || nosel) begin
            pready  = 1'b1;
            pslverr = 1'b1;
        end else if (in_access) begin
            prdata  = sel_data;
            pready  = sel_rdy;
            pslverr = sel_err & sel_rdy;
        end
    end

    assign err_timeout = in_force && !PRESET;

    // Phase tracking and watchdog: a slave completion beats the limit.
    always_comb begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        if (in_force) begin
            state_d = ST_IDLE;
        end else if (in_access) begin
            if (sel_rdy) begin
                state_d = ST_IDLE;
            end else if (hit_limit) begin
                state_d = ST_FORCE;
            end else begin
                state_d = ST_ACCESS;
                cnt_d   = (cnt_cur == CNT_MAX) ? cnt_cur : cnt_cur + CNT_W'(1);
            end
        end else if (any_sel && !penable) begin
            state_d = ST_SETUP;
        end
    end

    // State and counter registers.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Debug flags: sticky errors where a new event beats err_clr.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            err_multi <= 1'b0;
            err_nosel <= 1'b0;
            last_err  <= 1'b0;
        end else begin
            if (multi)        err_multi <= 1'b1;
            else if (err_clr) err_multi <= 1'b0;
            if (nosel)        err_nosel <= 1'b1;
            else if (err_clr) err_nosel <= 1'b0;
            if (pready)       last_err  <= pslverr;
        end
    end

endmodule

// File: tb/tb_apb_rsp_mux.sv
// Self-checking bench for apb_rsp_mux: directed scenarios plus randomized
// transfers, each cycle compared against a transfer-level reference model.
module tb_apb_rsp_mux;

    localparam int NS = 12;
    localparam int DW = 32;
    localparam int TO = 4;

    logic             PCLK = 1'b0;
    logic             PRESET;
    logic [NS-1:0]    psel, pready_s, pslverr_s;
    logic             penable, err_clr;
    logic [NS*DW-1:0] prdata_s;
    logic [DW-1:0]    prdata;
    logic             pready, pslverr, err_multi, err_timeout, err_nosel, last_err;

    int nvec = 0;
    int nmis = 0;

    // Reference model state: stalled access cycles so far, pending forced
    // completion, and the expected flag values.
    int       m_wait;
    bit       m_force;
    logic     m_multi, m_nosel, m_last;
    logic [DW-1:0] ed;
    logic     er, ee, et;

    apb_rsp_mux #(.NUM_SLAVES(NS), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .PCLK (PCLK), .PRESET (PRESET), .psel (psel), .penable (penable),
        .prdata_s (prdata_s), .pready_s (pready_s), .pslverr_s (pslverr_s),
        .err_clr (err_clr), .prdata (prdata), .pready (pready), .pslverr (pslverr),
        .err_multi (err_multi), .err_timeout (err_timeout), .err_nosel (err_nosel),
        .last_err (last_err)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic int lowest(input logic [NS-1:0] v);
        for (int i = 0; i < NS; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Expected response for the current cycle's inputs.
    function automatic void model_eval();
        int k;
        ed = '0; er = 1'b0; ee = 1'b0; et = 1'b0;
        if (PRESET) return;
        if (m_force) begin er = 1'b1; ee = 1'b1; et = 1'b1; return; end
        if (!penable) return;
        if (psel == '0) begin er = 1'b1; ee = 1'b1; return; end
        k  = lowest(psel);
        ed = prdata_s[k*DW +: DW];
        er = pready_s[k];
        ee = pslverr_s[k] & pready_s[k];
    endfunction

    // Advance the model across a clock edge.
    function automatic void model_tick();
        bit acc;
        acc = !m_force && penable && (psel != '0);
        if (PRESET) begin
            m_force = 0; m_wait = 0; m_multi = 0; m_nosel = 0; m_last = 0;
            return;
        end
        if ($countones(psel) > 1) m_multi = 1'b1; else if (err_clr) m_multi = 1'b0;
        if (!m_force && penable && psel == '0) m_nosel = 1'b1;
        else if (err_clr) m_nosel = 1'b0;
        if (er) m_last = ee;
        if (m_force) begin
            m_force = 0; m_wait = 0;
        end else if (acc && !er) begin
            m_wait++;
            if (TO != 0 && m_wait == TO) begin m_force = 1; m_wait = 0; end
        end else begin
            m_wait = 0;
        end
    endfunction

    task automatic sample();
        @(negedge PCLK);
        model_eval();
    endtask

    task automatic advance();
        @(posedge PCLK);
        model_tick();
        #1;
    endtask

    task automatic go_idle();
        psel = '0; penable = 1'b0; pready_s = '0; err_clr = 1'b0;
    endtask

    task automatic test_reset();
        PRESET = 1'b1; err_clr = 1'b0; psel = 12'h004; penable = 1'b1;
        pready_s = '1; pslverr_s = '1; prdata_s = {NS{32'hDEAD_BEEF}};
        m_wait = 0; m_force = 0; m_multi = 0; m_nosel = 0; m_last = 0;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) begin PRESET = 1'b0; go_idle(); end
            sample();
            nvec++;
            if ({prdata, pready, pslverr, err_timeout} !== {ed, er, ee, et}) begin
                nmis++;
                $display("FAIL reset_rsp cyc %0d: got %h %b%b%b, expected %h %b%b%b",
                         c, prdata, pready, pslverr, err_timeout, ed, er, ee, et);
            end
            nvec++;
            if ({err_multi, err_nosel, last_err} !== 3'b000) begin
                nmis++;
                $display("FAIL reset_flags cyc %0d: got %b%b%b, expected 000",
                         c, err_multi, err_nosel, last_err);
            end
            advance();
        end
    endtask

    task automatic test_normal_read();
        for (int i = 0; i < NS; i++) prdata_s[i*DW +: DW] = 32'hA5A5_0000 | 32'(i);
        pslverr_s = 12'hFFB;
        for (int c = 0; c < 4; c++) begin
            case (c)
                0: begin psel = 12'h004; penable = 1'b0; pready_s = 12'h004; end
                1: begin penable = 1'b1; pready_s = 12'hFFB; end
                2: begin pready_s = 12'h004; end
                default: go_idle();
            endcase
            sample();
            nvec++;
            if ({prdata, pready, pslverr, err_timeout} !== {ed, er, ee, et}) begin
                nmis++;
                $display("FAIL normal_rsp cyc %0d: got %h %b%b%b, expected %h %b%b%b",
                         c, prdata, pready, pslverr, err_timeout, ed, er, ee, et);
            end
            nvec++;
            if ({err_multi, err_nosel, last_err} !== {m_multi, m_nosel, m_last}) begin
                nmis++;
                $display("FAIL normal_flags cyc %0d: got %b%b%b, expected %b%b%b",
                         c, err_multi, err_nosel, last_err, m_multi, m_nosel, m_last);
            end
            if (c == 2) begin
                nvec++;
                if ({prdata, pready, pslverr} !== {32'hA5A5_0002, 1'b1, 1'b0}) begin
                    nmis++;
                    $display("FAIL normal_data: got %h %b%b, expected a5a50002 10",
                             prdata, pready, pslverr);
                end
            end
            advance();
        end
    endtask

    // race=0: slave never answers; race=1: slave answers on the limit cycle.
    task automatic test_watchdog(input bit race);
        int got;
        got = -1;
        prdata_s[4*DW +: DW] = 32'h0000_BEE4;
        pslverr_s = '0;
        psel = 12'h010; penable = 1'b0; pready_s = '0;
        for (int c = 0; c < 12 && got < 0; c++) begin
            if (c > 0) begin
                penable  = 1'b1;
                pready_s = NS'($urandom) & ~12'h010;
                if (race && c - 1 == TO - 1) pready_s[4] = 1'b1;
            end
            sample();
            nvec++;
            if ({prdata, pready, pslverr, err_timeout} !== {ed, er, ee, et}) begin
                nmis++;
                $display("FAIL wdog%0d_rsp cyc %0d: got %h %b%b%b, expected %h %b%b%b",
                         race, c, prdata, pready, pslverr, err_timeout, ed, er, ee, et);
            end
            if (er) got = c - 1;
            advance();
        end
        nvec++;
        if (got !== (race ? TO - 1 : TO)) begin
            nmis++;
            $display("FAIL wdog%0d_latency: completion at access cycle %0d, expected %0d",
                     race, got, race ? TO - 1 : TO);
        end
        go_idle();
        sample();
        nvec++;
        if ({err_timeout, pready, last_err} !== {1'b0, 1'b0, !race}) begin
            nmis++;
            $display("FAIL wdog%0d_after: got to=%b rdy=%b last=%b, expected 0 0 %b",
                     race, err_timeout, pready, last_err, !race);
        end
        advance();
    endtask

    task automatic test_multi();
        prdata_s[1*DW +: DW] = 32'h1111_0001;
        prdata_s[2*DW +: DW] = 32'h2222_0002;
        pslverr_s = '0;
        for (int c = 0; c < 5; c++) begin
            case (c)
                0: begin psel = 12'h006; penable = 1'b0; pready_s = '0; end
                1: begin penable = 1'b1; pready_s = 12'h002; end
                2: go_idle();
                3: err_clr = 1'b1;
                default: go_idle();
            endcase
            sample();
            nvec++;
            if ({prdata, pready, pslverr, err_timeout} !== {ed, er, ee, et}) begin
                nmis++;
                $display("FAIL multi_rsp cyc %0d: got %h %b%b%b, expected %h %b%b%b",
                         c, prdata, pready, pslverr, err_timeout, ed, er, ee, et);
            end
            nvec++;
            if ({err_multi, err_nosel, last_err} !== {m_multi, m_nosel, m_last}) begin
                nmis++;
                $display("FAIL multi_flags cyc %0d: got %b%b%b, expected %b%b%b",
                         c, err_multi, err_nosel, last_err, m_multi, m_nosel, m_last);
            end
            if (c == 1 || c == 2 || c == 4) begin
                nvec++;
                if (c == 1 ? (prdata !== 32'h1111_0001) : (err_multi !== (c == 2))) begin
                    nmis++;
                    $display("FAIL multi_fixed cyc %0d: got data %h multi %b", c, prdata, err_multi);
                end
            end
            advance();
        end
    endtask

    task automatic test_nosel();
        for (int c = 0; c < 4; c++) begin
            case (c)
                0: begin psel = '0; penable = 1'b1; pready_s = '1; end
                2: begin go_idle(); err_clr = 1'b1; end
                default: go_idle();
            endcase
            sample();
            nvec++;
            if ({prdata, pready, pslverr, err_timeout} !== {ed, er, ee, et}) begin
                nmis++;
                $display("FAIL nosel_rsp cyc %0d: got %h %b%b%b, expected %h %b%b%b",
                         c, prdata, pready, pslverr, err_timeout, ed, er, ee, et);
            end
            nvec++;
            if ({err_multi, err_nosel, last_err} !== {m_multi, m_nosel, m_last}) begin
                nmis++;
                $display("FAIL nosel_flags cyc %0d: got %b%b%b, expected %b%b%b",
                         c, err_multi, err_nosel, last_err, m_multi, m_nosel, m_last);
            end
            if (c == 0 || c == 1) begin
                nvec++;
                if (c == 0 ? ({prdata, pready, pslverr} !== {32'h0, 2'b11}) : (err_nosel !== 1'b1)) begin
                    nmis++;
                    $display("FAIL nosel_fixed cyc %0d: got data %h rdy %b err %b nosel %b",
                             c, prdata, pready, pslverr, err_nosel);
                end
            end
            advance();
        end
    endtask

    task automatic test_reset_mid();
        psel = 12'h010; penable = 1'b0; pready_s = '0; pslverr_s = '0;
        for (int c = 0; c < 7; c++) begin
            if (c >= 1 && c <= 4) penable = 1'b1;
            if (c == 4) PRESET = 1'b1;
            if (c == 5) begin PRESET = 1'b0; go_idle(); end
            sample();
            nvec++;
            if ({prdata, pready, pslverr, err_timeout} !== {ed, er, ee, et}) begin
                nmis++;
                $display("FAIL rstmid_rsp cyc %0d: got %h %b%b%b, expected %h %b%b%b",
                         c, prdata, pready, pslverr, err_timeout, ed, er, ee, et);
            end
            if (c >= 5) begin
                nvec++;
                if ({prdata, pready, pslverr, err_timeout} !== '0) begin
                    nmis++;
                    $display("FAIL rstmid_quiet cyc %0d: got %h %b%b%b, expected all zero",
                             c, prdata, pready, pslverr, err_timeout);
                end
            end
            advance();
        end
    endtask

    task automatic test_random();
        int kind, wt, k, done;
        logic [NS-1:0] s;
        for (int t = 0; t < 80; t++) begin
            kind = $urandom_range(0, 9);
            wt   = $urandom_range(0, 6);
            for (int i = 0; i < NS; i++) prdata_s[i*DW +: DW] = $urandom;
            pslverr_s = NS'($urandom);
            if (kind == 0)      s = '0;
            else if (kind == 1) s = NS'((1 << $urandom_range(0, NS-1)) | (1 << $urandom_range(0, NS-1)));
            else                s = NS'(1 << $urandom_range(0, NS-1));
            k    = lowest(s);
            done = 0;
            for (int c = 0; c < 14 && !done; c++) begin
                err_clr = ($urandom_range(0, 7) == 0);
                psel    = s;
                if (s == '0) begin
                    penable = 1'b1; pready_s = NS'($urandom);
                end else if (c == 0) begin
                    penable = 1'b0; pready_s = NS'($urandom);
                end else begin
                    penable  = 1'b1;
                    pready_s = NS'($urandom);
                    pready_s[k] = (c - 1 >= wt);
                end
                sample();
                nvec++;
                if ({prdata, pready, pslverr, err_timeout} !== {ed, er, ee, et}) begin
                    nmis++;
                    $display("FAIL rand_rsp t%0d cyc %0d: got %h %b%b%b, expected %h %b%b%b",
                             t, c, prdata, pready, pslverr, err_timeout, ed, er, ee, et);
                end
                nvec++;
                if ({err_multi, err_nosel, last_err} !== {m_multi, m_nosel, m_last}) begin
                    nmis++;
                    $display("FAIL rand_flags t%0d cyc %0d: got %b%b%b, expected %b%b%b",
                             t, c, err_multi, err_nosel, last_err, m_multi, m_nosel, m_last);
                end
                if (er) done = 1;
                advance();
            end
            if (!done) begin
                nvec++; nmis++;
                $display("FAIL rand_bound t%0d: transfer never completed", t);
            end
            if ($urandom_range(0, 1) == 1) begin go_idle(); sample(); advance(); end
        end
    endtask

    initial begin
        test_reset();
        test_normal_read();
        test_watchdog(1'b0);
        test_watchdog(1'b1);
        test_multi();
        test_nosel();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
